// File: rtl/rm_cmd_scheduler.sv
// rm_cmd_scheduler: buffers host insert/pop commands in two small FIFOs,
// arbitrates them fairly and drives one request at a time into the
// resource manager, returning pop data or a timeout to the requester.
//
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_ins_* / o_ins_ready             insert command channel (valid/ready)
//   i_pop_* / o_pop_ready             pop command channel (valid/ready)
//   i_bitmap_rst                      level request to clear the resource manager
//   o_insert_req/o_pop_req/o_bitmap_rst_req  single requests to resource manager
//   o_host_id_0/o_plane_id_0/o_meta_data     held insert fields
//   o_host_id_1/o_plane_id_1                 held pop fields
//   i_meta_data/i_meta_data_rdy       pop data from resource manager
//   o_rsp_valid/o_rsp_timeout/o_rsp_* pop response (single-cycle pulses)
//   o_busy                            scheduler not idle
//
// Optional feature: define RM_SCHED_STATS_EN to add the saturating 16-bit
// counters o_ins_cnt, o_pop_cnt and o_timeout_cnt.

`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 8
`endif
`ifndef NO_OF_TAG
`define NO_OF_TAG 64
`endif

module rm_cmd_scheduler #(
  parameter int unsigned MAX_HOST_NUMBER     = `MAX_HOST_NUMBER,
  parameter int unsigned MAX_PLANE_NUMBER    = `MAX_PLANE_NUMBER,
  parameter int unsigned HOST_ID_BIT_WIDTH   = $clog2(MAX_HOST_NUMBER),
  parameter int unsigned PLANE_ID_BIT_WIDTH  = $clog2(MAX_PLANE_NUMBER),
  parameter int unsigned META_DATA_BIT_WIDTH = 128 - $clog2(`NO_OF_TAG) - HOST_ID_BIT_WIDTH - 1,
  parameter int unsigned FIFO_DEPTH          = 4,
  parameter int unsigned INSERT_GUARD        = 32,
  parameter int unsigned POP_TIMEOUT         = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_ins_valid,
  output logic                           o_ins_ready,
  input  logic [HOST_ID_BIT_WIDTH-1:0]   i_ins_host_id,
  input  logic [PLANE_ID_BIT_WIDTH-1:0]  i_ins_plane_id,
  input  logic [META_DATA_BIT_WIDTH-1:0] i_ins_meta,
  input  logic                           i_pop_valid,
  output logic                           o_pop_ready,
  input  logic [HOST_ID_BIT_WIDTH-1:0]   i_pop_host_id,
  input  logic [PLANE_ID_BIT_WIDTH-1:0]  i_pop_plane_id,
  input  logic                           i_bitmap_rst,
  output logic                           o_insert_req,
  output logic                           o_pop_req,
  output logic                           o_bitmap_rst_req,
  output logic [HOST_ID_BIT_WIDTH-1:0]   o_host_id_0,
  output logic [PLANE_ID_BIT_WIDTH-1:0]  o_plane_id_0,
  output logic [META_DATA_BIT_WIDTH-1:0] o_meta_data,
  output logic [HOST_ID_BIT_WIDTH-1:0]   o_host_id_1,
  output logic [PLANE_ID_BIT_WIDTH-1:0]  o_plane_id_1,
  input  logic [META_DATA_BIT_WIDTH-1:0] i_meta_data,
  input  logic                           i_meta_data_rdy,
  output logic                           o_rsp_valid,
  output logic [META_DATA_BIT_WIDTH-1:0] o_rsp_meta,
  output logic [HOST_ID_BIT_WIDTH-1:0]   o_rsp_host_id,
  output logic [PLANE_ID_BIT_WIDTH-1:0]  o_rsp_plane_id,
  output logic                           o_rsp_timeout,
`ifdef RM_SCHED_STATS_EN
  output logic [15:0]                    o_ins_cnt,
  output logic [15:0]                    o_pop_cnt,
  output logic [15:0]                    o_timeout_cnt,
`endif
  output logic                           o_busy
);

  localparam int unsigned HW     = HOST_ID_BIT_WIDTH;
  localparam int unsigned PW     = PLANE_ID_BIT_WIDTH;
  localparam int unsigned MW     = META_DATA_BIT_WIDTH;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TMR_W  = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE_INS  = 3'd1,
    WAIT_INS   = 3'd2,
    ISSUE_POP  = 3'd3,
    WAIT_POP   = 3'd4,
    POP_SETTLE = 3'd5,
    RST_HOLD   = 3'd6,
    RST_SETTLE = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------- insert FIFO ----------------
  logic [HW-1:0]    r_ins_host_mem  [FIFO_DEPTH];
  logic [PW-1:0]    r_ins_plane_mem [FIFO_DEPTH];
  logic [MW-1:0]    r_ins_meta_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] r_ins_wr_ptr;
  logic [PTR_W-1:0] r_ins_rd_ptr;
  logic [CNT_W-1:0] r_ins_cnt;
  logic [CNT_W-1:0] w_ins_cnt_nxt;
  logic             r_ins_ready;
  logic             w_ins_push;
  logic             w_ins_deq;
  logic             w_ins_nempty;

  // ---------------- pop FIFO ----------------
  logic [HW-1:0]    r_pop_host_mem  [FIFO_DEPTH];
  logic [PW-1:0]    r_pop_plane_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_pop_wr_ptr;
  logic [PTR_W-1:0] r_pop_rd_ptr;
  logic [CNT_W-1:0] r_pop_cnt;
  logic [CNT_W-1:0] w_pop_cnt_nxt;
  logic             r_pop_ready;
  logic             w_pop_push;
  logic             w_pop_deq;
  logic             w_pop_nempty;

  // ---------------- control / held registers ----------------
  logic             r_last_pop;
  logic [TMR_W-1:0] r_tmr;
  logic             r_rdy_q;
  logic             w_rdy_rise;
  logic             w_rsp_hit;
  logic             w_rsp_to;

  logic             r_insert_req;
  logic             r_pop_req;
  logic             r_bitmap_rst_req;
  logic [HW-1:0]    r_host_id_0;
  logic [PW-1:0]    r_plane_id_0;
  logic [MW-1:0]    r_meta_data;
  logic [HW-1:0]    r_host_id_1;
  logic [PW-1:0]    r_plane_id_1;
  logic             r_rsp_valid;
  logic             r_rsp_timeout;
  logic [MW-1:0]    r_rsp_meta;
  logic [HW-1:0]    r_rsp_host_id;
  logic [PW-1:0]    r_rsp_plane_id;
  logic             r_busy;

  assign w_ins_push   = i_ins_valid & r_ins_ready;
  assign w_pop_push   = i_pop_valid & r_pop_ready;
  assign w_ins_nempty = (r_ins_cnt != '0);
  assign w_pop_nempty = (r_pop_cnt != '0);
  assign w_rdy_rise   = i_meta_data_rdy & ~r_rdy_q;

  // Occupancy next values; simultaneous push and dequeue leave the count as is.
  always_comb begin
    w_ins_cnt_nxt = r_ins_cnt;
    if (w_ins_push && !w_ins_deq)      w_ins_cnt_nxt = r_ins_cnt + CNT_W'(1);
    else if (!w_ins_push && w_ins_deq) w_ins_cnt_nxt = r_ins_cnt - CNT_W'(1);
  end

  always_comb begin
    w_pop_cnt_nxt = r_pop_cnt;
    if (w_pop_push && !w_pop_deq)      w_pop_cnt_nxt = r_pop_cnt + CNT_W'(1);
    else if (!w_pop_push && w_pop_deq) w_pop_cnt_nxt = r_pop_cnt - CNT_W'(1);
  end

  // FIFO storage (no reset needed: contents are qualified by the counts).
  always_ff @(posedge i_clk) begin
    if (w_ins_push) begin
      r_ins_host_mem[r_ins_wr_ptr]  <= i_ins_host_id;
      r_ins_plane_mem[r_ins_wr_ptr] <= i_ins_plane_id;
      r_ins_meta_mem[r_ins_wr_ptr]  <= i_ins_meta;
    end
    if (w_pop_push) begin
      r_pop_host_mem[r_pop_wr_ptr]  <= i_pop_host_id;
      r_pop_plane_mem[r_pop_wr_ptr] <= i_pop_plane_id;
    end
  end

  // FIFO pointers, counts and registered ready flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ins_wr_ptr <= '0;
      r_ins_rd_ptr <= '0;
      r_ins_cnt    <= '0;
      r_ins_ready  <= 1'b1;
      r_pop_wr_ptr <= '0;
      r_pop_rd_ptr <= '0;
      r_pop_cnt    <= '0;
      r_pop_ready  <= 1'b1;
    end else begin
      if (w_ins_push) r_ins_wr_ptr <= r_ins_wr_ptr + PTR_W'(1);
      if (w_ins_deq)  r_ins_rd_ptr <= r_ins_rd_ptr + PTR_W'(1);
      if (w_pop_push) r_pop_wr_ptr <= r_pop_wr_ptr + PTR_W'(1);
      if (w_pop_deq)  r_pop_rd_ptr <= r_pop_rd_ptr + PTR_W'(1);
      r_ins_cnt   <= w_ins_cnt_nxt;
      r_pop_cnt   <= w_pop_cnt_nxt;
      r_ins_ready <= (w_ins_cnt_nxt != CNT_W'(FIFO_DEPTH));
      r_pop_ready <= (w_pop_cnt_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; dequeue strobes fire on the IDLE->ISSUE edge so the
  // held fields are already valid during the issue cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ins_deq   = 1'b0;
    w_pop_deq   = 1'b0;
    w_rsp_hit   = 1'b0;
    w_rsp_to    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_bitmap_rst) begin
          w_state_nxt = RST_HOLD;
        end else if (w_ins_nempty && w_pop_nempty) begin
          if (r_last_pop) begin
            w_state_nxt = ISSUE_INS;
            w_ins_deq   = 1'b1;
          end else begin
            w_state_nxt = ISSUE_POP;
            w_pop_deq   = 1'b1;
          end
        end else if (w_ins_nempty) begin
          w_state_nxt = ISSUE_INS;
          w_ins_deq   = 1'b1;
        end else if (w_pop_nempty) begin
          w_state_nxt = ISSUE_POP;
          w_pop_deq   = 1'b1;
        end
      end
      ISSUE_INS:  w_state_nxt = WAIT_INS;
      WAIT_INS: begin
        if (r_tmr == '0) w_state_nxt = IDLE;
      end
      ISSUE_POP:  w_state_nxt = WAIT_POP;
      WAIT_POP: begin
        // Data arrival wins over an expiring timer in the same cycle.
        if (w_rdy_rise) begin
          w_rsp_hit   = 1'b1;
          w_state_nxt = POP_SETTLE;
        end else if (r_tmr == '0) begin
          w_rsp_to    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      POP_SETTLE: w_state_nxt = IDLE;
      RST_HOLD: begin
        if (!i_bitmap_rst) w_state_nxt = RST_SETTLE;
      end
      RST_SETTLE: w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Registered outputs, held request fields, wait timer and response capture.
  // The pop timer loads POP_TIMEOUT-2 so the timeout pulse (registered on
  // exit) lands exactly POP_TIMEOUT cycles after the issue cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_insert_req     <= 1'b0;
      r_pop_req        <= 1'b0;
      r_bitmap_rst_req <= 1'b0;
      r_host_id_0      <= '0;
      r_plane_id_0     <= '0;
      r_meta_data      <= '0;
      r_host_id_1      <= '0;
      r_plane_id_1     <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_timeout    <= 1'b0;
      r_rsp_meta       <= '0;
      r_rsp_host_id    <= '0;
      r_rsp_plane_id   <= '0;
      r_busy           <= 1'b0;
      r_last_pop       <= 1'b0;
      r_tmr            <= '0;
      r_rdy_q          <= 1'b0;
    end else begin
      r_insert_req     <= w_ins_deq;
      r_pop_req        <= w_pop_deq;
      r_bitmap_rst_req <= (w_state_nxt == RST_HOLD);
      r_busy           <= (w_state_nxt != IDLE);
      r_rsp_valid      <= w_rsp_hit;
      r_rsp_timeout    <= w_rsp_to;
      r_rdy_q          <= i_meta_data_rdy;
      if (w_ins_deq) begin
        r_host_id_0  <= r_ins_host_mem[r_ins_rd_ptr];
        r_plane_id_0 <= r_ins_plane_mem[r_ins_rd_ptr];
        r_meta_data  <= r_ins_meta_mem[r_ins_rd_ptr];
        r_last_pop   <= 1'b0;
      end
      if (w_pop_deq) begin
        r_host_id_1  <= r_pop_host_mem[r_pop_rd_ptr];
        r_plane_id_1 <= r_pop_plane_mem[r_pop_rd_ptr];
        r_last_pop   <= 1'b1;
      end
      if (r_state == ISSUE_INS)      r_tmr <= TMR_W'(INSERT_GUARD - 1);
      else if (r_state == ISSUE_POP) r_tmr <= TMR_W'(POP_TIMEOUT - 2);
      else if (r_tmr != '0)          r_tmr <= r_tmr - TMR_W'(1);
      if (w_rsp_hit) r_rsp_meta <= i_meta_data;
      if (w_rsp_hit || w_rsp_to) begin
        r_rsp_host_id  <= r_host_id_1;
        r_rsp_plane_id <= r_plane_id_1;
      end
    end
  end

`ifdef RM_SCHED_STATS_EN
  logic [15:0] r_ins_stat;
  logic [15:0] r_pop_stat;
  logic [15:0] r_to_stat;

  // Saturating event counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ins_stat <= '0;
      r_pop_stat <= '0;
      r_to_stat  <= '0;
    end else begin
      if (w_ins_deq && (r_ins_stat != 16'hFFFF)) r_ins_stat <= r_ins_stat + 16'd1;
      if (w_pop_deq && (r_pop_stat != 16'hFFFF)) r_pop_stat <= r_pop_stat + 16'd1;
      if (w_rsp_to  && (r_to_stat  != 16'hFFFF)) r_to_stat  <= r_to_stat  + 16'd1;
    end
  end

  assign o_ins_cnt     = r_ins_stat;
  assign o_pop_cnt     = r_pop_stat;
  assign o_timeout_cnt = r_to_stat;
`endif

  assign o_ins_ready      = r_ins_ready;
  assign o_pop_ready      = r_pop_ready;
  assign o_insert_req     = r_insert_req;
  assign o_pop_req        = r_pop_req;
  assign o_bitmap_rst_req = r_bitmap_rst_req;
  assign o_host_id_0      = r_host_id_0;
  assign o_plane_id_0     = r_plane_id_0;
  assign o_meta_data      = r_meta_data;
  assign o_host_id_1      = r_host_id_1;
  assign o_plane_id_1     = r_plane_id_1;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_timeout    = r_rsp_timeout;
  assign o_rsp_meta       = r_rsp_meta;
  assign o_rsp_host_id    = r_rsp_host_id;
  assign o_rsp_plane_id   = r_rsp_plane_id;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_rm_cmd_scheduler.sv
// Directed testbench for rm_cmd_scheduler (default build, stats disabled).
module tb_rm_cmd_scheduler;
  localparam int unsigned HW    = 2;
  localparam int unsigned PW    = 3;
  localparam int unsigned MW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GUARD = 8;
  localparam int unsigned PTO   = 8;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_ins_valid, i_pop_valid, i_bitmap_rst, i_meta_data_rdy;
  logic [HW-1:0] i_ins_host_id, i_pop_host_id;
  logic [PW-1:0] i_ins_plane_id, i_pop_plane_id;
  logic [MW-1:0] i_ins_meta, i_meta_data;
  logic          o_ins_ready, o_pop_ready, o_insert_req, o_pop_req, o_bitmap_rst_req;
  logic [HW-1:0] o_host_id_0, o_host_id_1, o_rsp_host_id;
  logic [PW-1:0] o_plane_id_0, o_plane_id_1, o_rsp_plane_id;
  logic [MW-1:0] o_meta_data, o_rsp_meta;
  logic          o_rsp_valid, o_rsp_timeout, o_busy;

  always #5 clk = ~clk;

  rm_cmd_scheduler #(
    .MAX_HOST_NUMBER(4), .MAX_PLANE_NUMBER(8),
    .HOST_ID_BIT_WIDTH(HW), .PLANE_ID_BIT_WIDTH(PW), .META_DATA_BIT_WIDTH(MW),
    .FIFO_DEPTH(DEPTH), .INSERT_GUARD(GUARD), .POP_TIMEOUT(PTO)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_ins_valid(i_ins_valid), .o_ins_ready(o_ins_ready),
    .i_ins_host_id(i_ins_host_id), .i_ins_plane_id(i_ins_plane_id), .i_ins_meta(i_ins_meta),
    .i_pop_valid(i_pop_valid), .o_pop_ready(o_pop_ready),
    .i_pop_host_id(i_pop_host_id), .i_pop_plane_id(i_pop_plane_id),
    .i_bitmap_rst(i_bitmap_rst),
    .o_insert_req(o_insert_req), .o_pop_req(o_pop_req), .o_bitmap_rst_req(o_bitmap_rst_req),
    .o_host_id_0(o_host_id_0), .o_plane_id_0(o_plane_id_0), .o_meta_data(o_meta_data),
    .o_host_id_1(o_host_id_1), .o_plane_id_1(o_plane_id_1),
    .i_meta_data(i_meta_data), .i_meta_data_rdy(i_meta_data_rdy),
    .o_rsp_valid(o_rsp_valid), .o_rsp_meta(o_rsp_meta),
    .o_rsp_host_id(o_rsp_host_id), .o_rsp_plane_id(o_rsp_plane_id),
    .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
  );

  // Event monitor: issue order (1 = pop, 0 = insert) and pulse counters.
  int          log_n = 0;
  logic [31:0] log_seq = '0;
  int          rst_req_cycles = 0;
  int          to_cnt = 0;
  int          rv_cnt = 0;

  always @(posedge clk) begin
    if (o_insert_req || o_pop_req) begin
      log_n   <= log_n + 1;
      log_seq <= {log_seq[30:0], o_pop_req};
    end
    if (o_bitmap_rst_req) rst_req_cycles <= rst_req_cycles + 1;
    if (o_rsp_timeout)    to_cnt <= to_cnt + 1;
    if (o_rsp_valid)      rv_cnt <= rv_cnt + 1;
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;
  int held;
  int base_n, base_to, base_rv, base_rst;

  initial begin
    i_rst_n = 1'b0;
    i_ins_valid = 1'b0; i_pop_valid = 1'b0; i_bitmap_rst = 1'b0; i_meta_data_rdy = 1'b0;
    i_ins_host_id = '0; i_ins_plane_id = '0; i_ins_meta = '0;
    i_pop_host_id = '0; i_pop_plane_id = '0; i_meta_data = '0;
    repeat (3) tick();
    chk("rst_ins_ready", 32'(o_ins_ready), 1);
    chk("rst_pop_ready", 32'(o_pop_ready), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_reqs", 32'({o_insert_req, o_pop_req, o_bitmap_rst_req}), 0);
    chk("rst_rsp", 32'({o_rsp_valid, o_rsp_timeout}), 0);
    i_rst_n = 1'b1;
    tick();

    // Single insert: host 2, plane 5, meta 0xABC.
    i_ins_valid = 1'b1; i_ins_host_id = 2'd2; i_ins_plane_id = 3'd5; i_ins_meta = 16'hABC;
    tick();
    i_ins_valid = 1'b0;
    chk("ins_no_req_t1", 32'(o_insert_req), 0);
    tick();
    chk("ins_req_t2", 32'(o_insert_req), 1);
    chk("ins_host", 32'(o_host_id_0), 2);
    chk("ins_plane", 32'(o_plane_id_0), 5);
    chk("ins_meta", 32'(o_meta_data), 32'hABC);
    chk("ins_busy", 32'(o_busy), 1);
    tick();
    chk("ins_req_single", 32'(o_insert_req), 0);
    n = 0; held = 1;
    while (o_busy && n < 100) begin
      n++;
      if (o_host_id_0 != 2'd2 || o_plane_id_0 != 3'd5 || o_meta_data != 16'hABC || o_insert_req)
        held = 0;
      tick();
    end
    chk("ins_guard_cycles", 32'(n), GUARD);
    chk("ins_fields_held", 32'(held), 1);
    chk("ins_idle", 32'(o_busy), 0);

    // Pop host 1 plane 3, data 0x55 returned three cycles after issue.
    i_pop_valid = 1'b1; i_pop_host_id = 2'd1; i_pop_plane_id = 3'd3;
    tick();
    i_pop_valid = 1'b0;
    tick();
    chk("pop_req", 32'(o_pop_req), 1);
    chk("pop_host", 32'(o_host_id_1), 1);
    chk("pop_plane", 32'(o_plane_id_1), 3);
    repeat (3) tick();
    chk("pop_no_rsp_yet", 32'(o_rsp_valid), 0);
    i_meta_data = 16'h55; i_meta_data_rdy = 1'b1;
    tick();
    chk("pop_rsp_valid", 32'(o_rsp_valid), 1);
    chk("pop_rsp_meta", 32'(o_rsp_meta), 32'h55);
    chk("pop_rsp_host", 32'(o_rsp_host_id), 1);
    chk("pop_rsp_plane", 32'(o_rsp_plane_id), 3);
    chk("pop_rsp_no_to", 32'(o_rsp_timeout), 0);
    i_meta_data_rdy = 1'b0; i_meta_data = '0;
    tick();
    chk("pop_rsp_pulse", 32'(o_rsp_valid), 0);
    chk("pop_rsp_meta_hold", 32'(o_rsp_meta), 32'h55);
    chk("pop_idle", 32'(o_busy), 0);

    // Pop timeout: host 3 plane 6, no data ever.
    i_pop_valid = 1'b1; i_pop_host_id = 2'd3; i_pop_plane_id = 3'd6;
    tick();
    i_pop_valid = 1'b0;
    tick();
    chk("to_pop_req", 32'(o_pop_req), 1);
    base_rv = rv_cnt;
    n = 0;
    while (!o_rsp_timeout && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), PTO);
    chk("to_host", 32'(o_rsp_host_id), 3);
    chk("to_plane", 32'(o_rsp_plane_id), 6);
    chk("to_meta_hold", 32'(o_rsp_meta), 32'h55);
    chk("to_no_valid", 32'(o_rsp_valid), 0);
    chk("to_valid_count", 32'(rv_cnt - base_rv), 0);
    chk("to_busy", 32'(o_busy), 0);
    tick();
    chk("to_pulse", 32'(o_rsp_timeout), 0);

    // Four inserts and four pops back-to-back, then a fifth pop into a full FIFO.
    base_n = log_n; base_to = to_cnt;
    for (int k = 0; k < 4; k++) begin
      i_ins_valid = 1'b1; i_ins_host_id = HW'(k); i_ins_plane_id = PW'(k); i_ins_meta = MW'(k);
      i_pop_valid = 1'b1; i_pop_host_id = HW'(k); i_pop_plane_id = PW'(k + 4);
      tick();
    end
    i_ins_valid = 1'b0;
    i_pop_host_id = 2'd0; i_pop_plane_id = 3'd7;
    chk("full_pop_ready", 32'(o_pop_ready), 0);
    chk("full_ins_ready", 32'(o_ins_ready), 1);
    n = 0;
    while (!o_pop_ready && n < 100) begin
      tick();
      n++;
    end
    chk("full_ready_return", 32'(n), 8);
    tick();
    i_pop_valid = 1'b0;
    chk("full_pop_accepted", 32'(o_pop_ready), 0);
    n = 0;
    while ((log_n - base_n) < 9 && n < 400) begin
      tick();
      n++;
    end
    n = 0;
    while (o_busy && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("order_count", 32'(log_n - base_n), 9);
    chk("order_seq", log_seq & 32'h1FF, 32'h0AB);
    chk("order_timeouts", 32'(to_cnt - base_to), 5);

    // Bitmap reset held 5 cycles with both FIFOs non-empty.
    base_n = log_n; base_rst = rst_req_cycles;
    i_ins_valid = 1'b1; i_ins_host_id = 2'd3; i_ins_plane_id = 3'd2; i_ins_meta = 16'h77;
    i_pop_valid = 1'b1; i_pop_host_id = 2'd2; i_pop_plane_id = 3'd1;
    i_bitmap_rst = 1'b1;
    tick();
    i_ins_valid = 1'b0; i_pop_valid = 1'b0;
    chk("brst_req_on", 32'(o_bitmap_rst_req), 1);
    repeat (4) tick();
    i_bitmap_rst = 1'b0;
    tick();
    chk("brst_req_off", 32'(o_bitmap_rst_req), 0);
    tick();
    chk("brst_req_cycles", 32'(rst_req_cycles - base_rst), 5);
    chk("brst_no_issue", 32'(log_n - base_n), 0);
    tick();
    chk("brst_ins_after", 32'(o_insert_req), 1);
    chk("brst_ins_host", 32'(o_host_id_0), 3);
    n = 0;
    while ((log_n - base_n) < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("brst_issue_order", log_seq & 32'h3, 32'h1);
    n = 0;
    while (o_busy && n < 100) begin
      tick();
      n++;
    end
    tick();

    // Reset during WAIT_INS with three commands still queued.
    i_ins_valid = 1'b1; i_ins_host_id = 2'd1; i_ins_plane_id = 3'd1; i_ins_meta = 16'h111;
    i_pop_valid = 1'b1; i_pop_host_id = 2'd1; i_pop_plane_id = 3'd2;
    tick();
    i_pop_valid = 1'b0; i_ins_host_id = 2'd2;
    tick();
    i_ins_host_id = 2'd3;
    tick();
    i_ins_valid = 1'b0;
    tick();
    chk("mid_busy", 32'(o_busy), 1);
    chk("mid_host", 32'(o_host_id_0), 1);
    i_rst_n = 1'b0;
    #1;
    chk("arst_reqs", 32'({o_insert_req, o_pop_req, o_bitmap_rst_req}), 0);
    chk("arst_fields0", 32'({o_host_id_0, o_plane_id_0, o_meta_data}), 0);
    chk("arst_fields1", 32'({o_host_id_1, o_plane_id_1}), 0);
    chk("arst_rsp", 32'({o_rsp_valid, o_rsp_timeout, o_rsp_host_id, o_rsp_plane_id}), 0);
    chk("arst_rsp_meta", 32'(o_rsp_meta), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_ready", 32'({o_ins_ready, o_pop_ready}), 3);
    tick();
    i_rst_n = 1'b1;
    base_n = log_n;
    repeat (40) tick();
    chk("arst_no_issue", 32'(log_n - base_n), 0);
    chk("arst_idle", 32'(o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
